// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and defaults for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 4;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin pick starting at ptr
module fifo_wr_arbiter_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N),
    localparam int IW1 = IW + 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);
    logic [IW:0] cand;

    // Walk offsets from farthest to nearest so the last hit is the closest to ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + IW1'(k);
            if (cand >= IW1'(N)) begin
                cand = cand - IW1'(N);
            end
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst round-robin arbiter for the async FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_wr_arbiter_pkg::NUM_REQ_DEF,
    parameter int MAX_BURST  = fifo_wr_arbiter_pkg::MAX_BURST_DEF,
    parameter int DATA_WIDTH = fifo_wr_arbiter_pkg::DATA_WIDTH,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                               w_clk,
    input  logic                               wrst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 gnt,
    input  logic                               f_full,
    output logic                               w_en,
    output logic [DATA_WIDTH-1:0]              d_out,
    output logic                               busy,
    output logic [IDW-1:0]                     owner_id
);
    import fifo_wr_arbiter_pkg::*;

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0] owner_next;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic           own_req;
    logic           beat;

    fifo_wr_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt        = '0;
        w_en       = 1'b0;
        d_out      = '0;
        beat       = 1'b0;
        own_req    = req[owner_q];
        owner_next = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                beat         = own_req & ~f_full;
                w_en         = beat;
                gnt[owner_q] = beat;
                if (own_req) begin
                    d_out = req_data[owner_q];
                end
                // A dropped request ends the burst even while the FIFO is full.
                if (!own_req || (beat && (req_last[owner_q] ||
                                          beat_cnt_q == CW'(MAX_BURST - 1)))) begin
                    state_d    = IDLE;
                    rr_ptr_d   = owner_next;
                    beat_cnt_d = '0;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign busy     = (state_q == BURST);
    assign owner_id = owner_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write-port arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int DW = 32;

    logic                 w_clk = 1'b0;
    logic                 wrst  = 1'b1;
    logic [N-1:0]         req = '0;
    logic [N-1:0][DW-1:0] req_data = '0;
    logic [N-1:0]         req_last = '0;
    logic [N-1:0]         gnt;
    logic                 f_full = 1'b0;
    logic                 w_en;
    logic [DW-1:0]        d_out;
    logic                 busy;
    logic [1:0]           owner_id;

    always #5 w_clk = ~w_clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .DATA_WIDTH(DW)) dut (
        .w_clk    (w_clk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .f_full   (f_full),
        .w_en     (w_en),
        .d_out    (d_out),
        .busy     (busy),
        .owner_id (owner_id)
    );

    typedef struct {
        int            cyc;
        bit            busy;
        int            owner;
        logic [N-1:0]  gnt;
        bit            wen;
        logic [DW-1:0] dout;
    } st_t;

    typedef struct {
        int            cyc;
        int            who;
        logic [DW-1:0] dat;
    } wr_t;

    st_t sq[$];
    wr_t wq[$];
    int  passed = 0;
    int  total  = 0;
    int  cyc    = 0;

    // Producers: each offers a burst of p_len beats (0 = never signals last).
    bit            p_act[N];
    int            p_len[N];
    int            p_b[N];
    logic [DW-1:0] p_base[N];
    bit            p_rep[N];

    // Reference model: whether a grant is held, by whom, where the search starts, beats done.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic start(input int i, input logic [DW-1:0] base, input int len, input bit rep);
        p_act[i]  = 1'b1;
        p_base[i] = base;
        p_len[i]  = len;
        p_b[i]    = 0;
        p_rep[i]  = rep;
    endtask

    task automatic stop_all();
        for (int i = 0; i < N; i++) p_act[i] = 1'b0;
    endtask

    task automatic run_cycle(input bit rst, input bit full);
        st_t s;
        wr_t w;
        int  o;
        bit  hit;
        @(posedge w_clk);
        #1;
        cyc++;
        wrst   = rst;
        f_full = full;
        for (int i = 0; i < N; i++) begin
            req[i] = p_act[i];
            if (p_act[i]) begin
                req_data[i] = p_base[i] + DW'(p_b[i]);
                req_last[i] = (p_len[i] != 0) && (p_b[i] == p_len[i] - 1);
            end else begin
                req_data[i] = $urandom;
                req_last[i] = 1'($urandom_range(0, 1));
            end
        end

        s.cyc   = cyc;
        s.busy  = m_busy;
        s.owner = m_owner;
        s.gnt   = '0;
        s.wen   = 1'b0;
        s.dout  = '0;
        if (m_busy) begin
            if (req[m_owner]) s.dout = req_data[m_owner];
            if (req[m_owner] && !full) begin
                s.wen = 1'b1;
                s.gnt[m_owner] = 1'b1;
            end
        end
        sq.push_back(s);

        if (s.wen) begin
            w.cyc = cyc;
            w.who = m_owner;
            w.dat = s.dout;
            wq.push_back(w);
            o = m_owner;
            p_b[o]++;
            if (p_len[o] != 0 && p_b[o] == p_len[o]) begin
                p_b[o]    = 0;
                p_base[o] = p_base[o] + 32'h100;
                if (!p_rep[o]) p_act[o] = 1'b0;
            end
        end

        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!hit && req[(m_ptr + k) % N]) begin
                    hit     = 1'b1;
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 1'b1;
                    m_cnt   = 0;
                end
            end
        end else if (!req[m_owner]) begin
            m_busy = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
        end else if (!full) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_busy = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
            end
        end
    endtask

    always @(negedge w_clk) begin : monitor
        st_t s;
        wr_t w;
        if (sq.size() > 0) begin
            s = sq.pop_front();
            chk("busy",     busy,     s.busy);
            chk("owner_id", owner_id, s.owner);
            chk("gnt",      gnt,      s.gnt);
            chk("w_en",     w_en,     s.wen);
            chk("d_out",    d_out,    s.dout);
            chk("gnt_onehot0",      $onehot0(gnt), 1);
            chk("wen_eq_any_gnt",   w_en,          |gnt);
            chk("wen_while_full",   w_en & f_full, 0);
            chk("wen_without_busy", w_en & ~busy,  0);
            if (w_en === 1'b1) begin
                chk("write_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("write_cycle", cyc, w.cyc);
                    chk("write_data",  d_out, w.dat);
                    chk("write_gnt",   gnt, N'(1) << w.who);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            p_act[i] = 1'b0; p_len[i] = 0; p_b[i] = 0; p_base[i] = '0; p_rep[i] = 1'b0;
        end

        // Reset held with everyone requesting, then release.
        for (int i = 0; i < N; i++) start(i, DW'(i) << 24, 1, 1'b1);
        repeat (3) run_cycle(1'b1, 1'b0);
        repeat (4) run_cycle(1'b0, 1'b0);
        stop_all();
        repeat (2) run_cycle(1'b0, 1'b0);

        // Single three-beat burst from requester 2.
        start(2, 32'hA0, 3, 1'b0);
        repeat (6) run_cycle(1'b0, 1'b0);

        // Burst cap with a lone requester that never signals last.
        start(0, 32'h300, 0, 1'b0);
        repeat (12) run_cycle(1'b0, 1'b0);
        stop_all();
        repeat (2) run_cycle(1'b0, 1'b0);

        // One-beat bursts from 0, 1 and 3.
        start(0, 32'h1000, 1, 1'b1);
        start(1, 32'h2000, 1, 1'b1);
        start(3, 32'h3000, 1, 1'b1);
        repeat (12) run_cycle(1'b0, 1'b0);
        stop_all();
        repeat (2) run_cycle(1'b0, 1'b0);

        // Backpressure after two beats of owner 1.
        start(1, 32'h500, 4, 1'b0);
        repeat (3) run_cycle(1'b0, 1'b0);
        repeat (5) run_cycle(1'b0, 1'b1);
        repeat (4) run_cycle(1'b0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0);

        // Owner 3 abandons after one beat; pointer should then favour 0.
        start(3, 32'h600, 0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0);
        p_act[3] = 1'b0;
        run_cycle(1'b0, 1'b0);
        start(0, 32'h680, 1, 1'b0);
        start(3, 32'h6C0, 1, 1'b0);
        repeat (5) run_cycle(1'b0, 1'b0);

        // Reset in the middle of a burst.
        start(2, 32'h700, 0, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0);
        run_cycle(1'b1, 1'b0);
        repeat (2) run_cycle(1'b0, 1'b0);
        stop_all();
        repeat (2) run_cycle(1'b0, 1'b0);

        // Random traffic, backpressure, abandons and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_act[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        start(i, $urandom, int'($urandom_range(0, 6)), 1'b0);
                end else if ($urandom_range(0, 49) == 0) begin
                    p_act[i] = 1'b0;
                end
            end
            run_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0);
        end

        @(negedge w_clk);
        #1;
        chk("writes_drained", wq.size(), 0);
        chk("status_drained", sq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single FIFO write port (w_en / d_out into fifo_mem) between NUM_REQ producers in the write-clock domain.
- Grants are burst-oriented. An owner holds the port until it signals last, reaches MAX_BURST beats, or drops its request.
- Honors f_full backpressure so no beat is issued while the FIFO is full.
- Sits between the producer logic and the async_fifo write side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant (1..16).
- DATA_WIDTH, pkg::DATA_WIDTH (32), write data width.

Ports:
- w_clk  in  1  write-domain clock; all logic is on its rising edge.
- wrst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- req_last  in  NUM_REQ  marks the final beat of the requester's burst.
- gnt  out  NUM_REQ  one-hot beat accept. The beat is consumed on a cycle where gnt[i] is 1.
- f_full  in  1  FIFO full flag from the write-pointer logic.
- w_en  out  1  FIFO write enable.
- d_out  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high while in BURST.
- owner_id  out  $clog2(NUM_REQ)  current or last owner index.

Behaviour:
- Reset (wrst=1 at a w_clk edge):
  - state=IDLE, rr_ptr=0, owner_id=0, beat_cnt=0.
  - Outputs: gnt=0, w_en=0, busy=0, d_out=0.
  - Reset mid-burst abandons the burst; no further beat is issued.
- Registered state is {state, owner_id, rr_ptr, beat_cnt}.
- w_en, gnt and d_out are combinational from the registered state plus req/f_full. They therefore act in the same cycle, so fifo_mem sees a beat only when f_full=0.
- IDLE:
  - w_en=0, gnt=0, d_out=0.
  - If req!=0, select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register owner_id=i, beat_cnt=0, and go to BURST.
  - Arbitration costs exactly one IDLE cycle per burst.
  - If req=0, stay in IDLE.
- BURST:
  - beat = req[owner_id] & ~f_full.
  - w_en=beat; gnt[owner_id]=beat; other gnt bits are 0.
  - d_out = req_data[owner_id] while req[owner_id]=1, else 0.
  - On a beat: beat_cnt++.
  - Burst end: a beat with req_last[owner_id]=1 or beat_cnt==MAX_BURST-1. Then go to IDLE, rr_ptr=(owner_id+1) mod NUM_REQ, beat_cnt=0.
  - Abandon: req[owner_id]=0 (regardless of f_full) ends the burst with no write. Go to IDLE and advance rr_ptr the same way.
  - f_full=1 with req[owner_id]=1: stall. No beat, no state change, grant retained, beat_cnt held.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1.
  - The rr_ptr wrap NUM_REQ-1 → 0 is explicit; NUM_REQ need not be a power of 2.
- Non-owner requests are ignored during BURST; they see gnt=0 and must hold req/req_data.
- req_last on a non-owner has no effect.
- MAX_BURST=1 degenerates to per-beat round robin with an IDLE cycle between beats.
- Assertions:
  - gnt is one-hot-or-zero.
  - w_en == |gnt.
  - w_en → !f_full.
  - w_en → busy.

Decomposition:
- Shared pkg additions:
  - arb_state_e enum {IDLE, BURST}.
  - Constants NUM_REQ_DEF=4 and MAX_BURST_DEF=4.
  - DATA_WIDTH and ADDR_WIDTH are reused from pkg.
- One sub-module is natural: rr_pick. It is combinational: given req and rr_ptr, it returns a found flag and an index. It is reused by the read-side scheduler later.
- The arbiter instance drives w_en and d_out on the async_fifo interface.

Test Plan:
1. Reset: hold wrst=1 for 3 cycles with req=4'b1111 → gnt=0, w_en=0, busy=0, owner_id=0. First release cycle is IDLE. The next cycle owner_id=0 and busy=1.
2. Single burst: req[2]=1 with data 0xA0..0xA2, req_last on the 3rd beat, f_full=0 → one IDLE cycle, then 3 consecutive w_en with d_out=0xA0,0xA1,0xA2 and gnt=4'b0100. Then IDLE with rr_ptr=3.
3. MAX_BURST cap: req[0] held continuously, no last → 4 beats, IDLE, then owner 0 again (the only requester). Pattern is 4 writes per 5 cycles.
4. Round robin: req=4'b1011 all held continuously, 1-beat bursts (last=1) → owner sequence 0,1,3,0,1,3. No gnt to requester 2.
5. Backpressure: owner 1 mid-burst after 2 beats, f_full=1 for 5 cycles → w_en=0, gnt=0, busy=1, beat_cnt=2 held. After f_full=0, the remaining 2 beats are written and the burst ends at 4 beats.
6. Abandon and reset mid-burst:
   - Owner 3 drops req after 1 beat → IDLE next cycle, rr_ptr=0, no extra write.
   - Separately, wrst=1 during BURST → next cycle IDLE, w_en=0, rr_ptr=0.
